vga_timing_gen: RTL

- Upstream neighbour of the frame-buffer address generator; produces the pixel-rate enable, `h_cnt`/`v_cnt` and sync/valid timing for 640x480@60.
- Downstream, `h_cnt`/`v_cnt` feed the address generator, which addresses the 320x240 BRAM frame buffer.
- Also provides sync/valid delayed by a parameterised number of pixel periods, so they align with BRAM read data at the VGA pins.

---
 rtl/vga_timing_gen_pkg.sv | 44 ++++
 rtl/vga_timing_gen_if.sv | 34 +++
 rtl/vga_timing_gen_sync_delay_line.sv | 40 ++++
 rtl/vga_timing_gen.sv | 138 +++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and types for the VGA timing generator and its neighbours.
// Holds the 640x480@60 default geometry, the derived totals and the sync
// window indices. It also holds the frame-buffer size that the downstream
// address generator uses, and the bundled {valid, hsync, vsync} type.
package vga_timing_pkg;

    localparam int CNT_W   = 10;
    localparam int CNT_MAX = 1 << CNT_W;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int HSYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int HSYNC_END_DEF   = HSYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int VSYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int VSYNC_END_DEF   = VSYNC_START_DEF + V_SYNC_DEF - 1;

    // Frame buffer is 320x240, pixel-doubled onto the 640x480 raster.
    localparam int FB_W = 320;
    localparam int FB_H = 240;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic valid;
        logic hsync;
        logic vsync;
    } timing_t;

    // Map a logical "sync active" flag onto the pin level for a polarity.
    function automatic logic sync_level(input logic active, input bit pol);
        return pol ? active : ~active;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle produced by vga_timing_gen. The master modport drives it.
// The slave modport is for consumers such as the frame-buffer address
// generator and the VGA pin stage.
//   pclk_en      one-clk pixel strobe
//   h_cnt/v_cnt  raster position
//   valid/hsync/vsync            decoded timing, aligned with the counters
//   line_start/frame_start       one-clk pulses on the first clk of a new line/frame
//   valid_d/hsync_d/vsync_d      timing delayed by SYNC_DELAY pixel periods
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic pclk_en;
    cnt_t h_cnt;
    cnt_t v_cnt;
    logic valid;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
    logic valid_d;
    logic hsync_d;
    logic vsync_d;

    modport master (
        output pclk_en, h_cnt, v_cnt, valid, hsync, vsync,
               line_start, frame_start, valid_d, hsync_d, vsync_d
    );

    modport slave (
        input  pclk_en, h_cnt, v_cnt, valid, hsync, vsync,
               line_start, frame_start, valid_d, hsync_d, vsync_d
    );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// DEPTH-stage register chain that advances only when en is high.
// Each bit has its own reset value, so sync lines come up at their idle level.
// With DEPTH=0 the chain collapses to a wire.
//   clk, rst  clock and asynchronous active-high reset
//   en        advance strobe
//   d, q      WIDTH-bit input and DEPTH-step delayed output
module sync_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, en};
            assign q = d;
        end else begin : g_chain
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
                end else if (en) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator (default 640x480@60 from 100 MHz).
// It divides clk down to a pixel strobe and runs the h/v counters on that
// strobe. It decodes valid/hsync/vsync with zero latency relative to the
// counters. It also provides a copy of the timing delayed to line up with
// frame-buffer read data.
//   clk  system clock
//   rst  asynchronous active-high reset
//   tim  timing bundle (master side), see vga_timing_gen_if
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int CLK_DIV    = 4,
    parameter int SYNC_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  tim
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > CNT_MAX) begin : g_h_total_too_big
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > CNT_MAX) begin : g_v_total_too_big
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (CLK_DIV < 1) begin : g_clk_div_bad
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (SYNC_DELAY < 0) begin : g_sync_delay_bad
        $error("vga_timing_gen: SYNC_DELAY must be >= 0");
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS_C    = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS_C    = cnt_t'(V_VISIBLE);
    localparam cnt_t HS_START_C = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t HS_END_C   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam cnt_t VS_START_C = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t VS_END_C   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam timing_t TIMING_IDLE = '{valid: 1'b0, hsync: !HSYNC_POL, vsync: !VSYNC_POL};

    function automatic timing_t decode(input cnt_t h, input cnt_t v);
        timing_t t;
        t.valid = (h < H_VIS_C) && (v < V_VIS_C);
        t.hsync = sync_level((h >= HS_START_C) && (h <= HS_END_C), HSYNC_POL);
        t.vsync = sync_level((v >= VS_START_C) && (v <= VS_END_C), VSYNC_POL);
        return t;
    endfunction

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             pclk_en;
    cnt_t             h_cnt, v_cnt;
    cnt_t             h_nxt, v_nxt;
    logic             line_start, frame_start;
    timing_t          cur, cur_d;

    // tick is the edge on which pclk_en rises and the counters step. The new
    // position and its pclk_en strobe therefore appear in the same clk.
    assign tick = (div_cnt == DIV_LAST);

    always_comb begin
        h_nxt = h_cnt + 1'b1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            pclk_en     <= 1'b0;
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            cur         <= TIMING_IDLE;
        end else begin
            div_cnt     <= tick ? '0 : div_cnt + 1'b1;
            pclk_en     <= tick;
            line_start  <= tick && (h_nxt == '0);
            frame_start <= tick && (h_nxt == '0) && (v_nxt == '0);
            if (tick) begin
                h_cnt <= h_nxt;
                v_cnt <= v_nxt;
                // Decode from the next counts so the flags land with the counters.
                cur   <= decode(h_nxt, v_nxt);
            end
        end
    end

    // The chain shifts on the same edge that starts a new pixel. Each stage
    // therefore holds its value for exactly one pixel period.
    sync_delay_line #(
        .WIDTH   (3),
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (TIMING_IDLE)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .en  (tick),
        .d   (cur),
        .q   (cur_d)
    );

    assign tim.pclk_en     = pclk_en;
    assign tim.h_cnt       = h_cnt;
    assign tim.v_cnt       = v_cnt;
    assign tim.valid       = cur.valid;
    assign tim.hsync       = cur.hsync;
    assign tim.vsync       = cur.vsync;
    assign tim.line_start  = line_start;
    assign tim.frame_start = frame_start;
    assign tim.valid_d     = cur_d.valid;
    assign tim.hsync_d     = cur_d.hsync;
    assign tim.vsync_d     = cur_d.vsync;

endmodule
